// File: rtl/uart_err_cnt_bank.sv
// Per-channel UART receive error counters with saturate/wrap, sticky overflow and a registered
// read port with optional clear-on-read. Define ERR_CNT_THRESH_IRQ_EN for threshold interrupts.
module uart_err_cnt_bank #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       clr_ch,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       err,
  input  logic                    edge_done,
  input  logic                    sat_mode,
  input  logic                    rd_en,
  input  logic [SEL_W-1:0]        rd_sel,
  input  logic                    rd_clr,
`ifdef ERR_CNT_THRESH_IRQ_EN
  input  logic [CNT_W-1:0]        thresh,
  input  logic [NUM_CH-1:0]       irq_mask,
  output logic                    irq,
  output logic [NUM_CH-1:0]       irq_stat,
`endif
  output logic [CNT_W-1:0]        rd_data,
  output logic                    rd_valid,
  output logic [NUM_CH*CNT_W-1:0] cnt_flat,
  output logic [NUM_CH-1:0]       ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_all;
  logic                         sel_in_range;
  logic [CNT_W-1:0]             rd_data_q, rd_data_d;
  logic                         rd_valid_q;
`ifdef ERR_CNT_THRESH_IRQ_EN
  logic [NUM_CH-1:0]            irq_stat_all;
  logic                         irq_q, irq_d;
`endif

  assign cnt_flat     = cnt_all;
  assign sel_in_range = (32'(rd_sel) < NUM_CH);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             inc, hard_clr, rd_clr_hit;

    assign inc        = en & edge_done & err[gi];
    assign hard_clr   = clr | clr_ch[gi];
    assign rd_clr_hit = rd_en & rd_clr & (32'(rd_sel) == gi);

    // Hard clears drop a coincident event; a read-clear keeps it as a count of one.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (hard_clr) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (rd_clr_hit) begin
        cnt_d = inc ? CNT_W'(1) : '0;
        ovf_d = 1'b0;
      end else if (inc) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = sat_mode ? CNT_MAX : '0;
          ovf_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt_all[gi] = cnt_q;
    assign ovf[gi]     = ovf_q;

`ifdef ERR_CNT_THRESH_IRQ_EN
    logic ist_q, ist_d;

    // Set only when an increment lands exactly on a non-zero threshold.
    always_comb begin
      ist_d = (hard_clr | rd_clr_hit) ? 1'b0 : ist_q;
      if (!hard_clr && inc && (thresh != '0) && (cnt_d == thresh)) begin
        ist_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ist_q <= 1'b0;
      end else begin
        ist_q <= ist_d;
      end
    end

    assign irq_stat_all[gi] = ist_q;
`endif
  end

  // Read data captures the counter value before this cycle's update.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = sel_in_range ? cnt_all[rd_sel] : '0;
    end
  end

`ifdef ERR_CNT_THRESH_IRQ_EN
  assign irq_d = |(irq_stat_all & irq_mask);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef ERR_CNT_THRESH_IRQ_EN
      irq_q      <= 1'b0;
`endif
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
`ifdef ERR_CNT_THRESH_IRQ_EN
      irq_q      <= irq_d;
`endif
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`ifdef ERR_CNT_THRESH_IRQ_EN
  assign irq      = irq_q;
  assign irq_stat = irq_stat_all;
`endif

endmodule
